// File: rtl/decode_rob_pkg.sv
// decode_rob_pkg: shared ROB sizing constants and the allocator FSM encoding.
package decode_rob_pkg;
  localparam int ROB_AW    = 4;
  localparam int ROB_DEPTH = 2 ** ROB_AW;
  localparam int FID_W     = 8;
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} rob_state_e;
endpackage

// File: rtl/decode_rob_ptr.sv
// decode_rob_ptr: wrap-bit pointer register; load takes priority over increment.
module decode_rob_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_inc,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_q <= '0;
    else         r_q <= i_load ? i_val : r_q + W'(i_inc);
  assign o_q = r_q;
endmodule

// File: rtl/decode_rob_ctrl.sv
// decode_rob_ctrl: ROB entry allocation, writeback tracking and in-order commit,
// with a one-cycle flush state after branch correction or snoop hit.
module decode_rob_ctrl
  import decode_rob_pkg::*;
#(
  parameter int ROB_AW = decode_rob_pkg::ROB_AW,
  parameter int FID_W  = decode_rob_pkg::FID_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              bco_valid,
  input  logic              snoop_hit,
  input  logic              alloc_req,
  output logic              alloc_ready,
  output logic [ROB_AW-1:0] alloc_rob,
  output logic [FID_W-1:0]  alloc_fid,
  input  logic              wb_en,
  input  logic [ROB_AW-1:0] wb_rob,
  output logic              commit_valid,
  output logic [ROB_AW-1:0] commit_rob,
  input  logic              commit_ready,
  output logic [ROB_AW:0]   count,
  output logic              empty,
  output logic              full
);
  localparam int DEPTH = 2 ** ROB_AW;
  rob_state_e r_state, w_state_nxt;
  logic [DEPTH-1:0] r_done, w_done_nxt;
  logic [FID_W-1:0] r_fid;
  logic [ROB_AW:0] w_head, w_tail;
  logic [ROB_AW-1:0] w_head_idx, w_tail_idx, w_wb_off;
  logic w_flush, w_alloc, w_commit, w_wb;

  decode_rob_ptr #(.W(ROB_AW + 1)) u_head (
    .clk(clk), .resetn(resetn), .i_inc(w_commit), .i_load(1'b0),
    .i_val('0), .o_q(w_head)
  );
  decode_rob_ptr #(.W(ROB_AW + 1)) u_tail (
    .clk(clk), .resetn(resetn), .i_inc(w_alloc), .i_load(w_flush),
    .i_val(w_head), .o_q(w_tail)
  );

  assign w_head_idx   = w_head[ROB_AW-1:0];
  assign w_tail_idx   = w_tail[ROB_AW-1:0];
  assign empty        = w_head == w_tail;
  assign full         = (w_head_idx == w_tail_idx) && (w_head[ROB_AW] != w_tail[ROB_AW]);
  assign count        = w_tail - w_head;
  assign w_flush      = bco_valid || snoop_hit;
  assign alloc_ready  = (r_state == RUN) && !full && !w_flush;
  assign alloc_rob    = w_tail_idx;
  assign alloc_fid    = r_fid;
  assign commit_valid = (r_state == RUN) && !empty && r_done[w_head_idx];
  assign commit_rob   = w_head_idx;
  assign w_alloc      = alloc_req && alloc_ready;
  assign w_commit     = commit_valid && commit_ready && !w_flush;
  // Distance from head below occupancy means wb_rob sits inside [head, tail).
  assign w_wb_off     = wb_rob - w_head_idx;
  assign w_wb         = wb_en && !w_flush && ({1'b0, w_wb_off} < count);

  always_comb begin
    w_state_nxt = w_flush ? FLUSH : RUN;
    w_done_nxt  = r_done;
    if (w_wb) w_done_nxt[wb_rob] = 1'b1;
    if (w_alloc) w_done_nxt[w_tail_idx] = 1'b0;
    if (w_commit) w_done_nxt[w_head_idx] = 1'b0;
    if (w_flush) w_done_nxt = '0;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state <= RUN;
      r_done  <= '0;
      r_fid   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_fid   <= r_fid + FID_W'(w_alloc);
    end
endmodule

// File: tb/tb_decode_rob_ctrl.sv
// tb_decode_rob_ctrl: vector table, hand-written corner sequences and random
// traffic checked against a queue-based ROB model.
module tb_decode_rob_ctrl;
  logic clk = 1'b0, resetn = 1'b0;
  logic bco_valid = 0, snoop_hit = 0, alloc_req = 0, wb_en = 0, commit_ready = 0;
  logic [3:0] wb_rob = '0;
  logic alloc_ready, commit_valid, empty, full;
  logic [3:0] alloc_rob, commit_rob;
  logic [7:0] alloc_fid;
  logic [4:0] count;
  int n_chk = 0, n_err = 0;

  decode_rob_ctrl dut (
    .clk(clk), .resetn(resetn), .bco_valid(bco_valid), .snoop_hit(snoop_hit),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_rob(alloc_rob),
    .alloc_fid(alloc_fid), .wb_en(wb_en), .wb_rob(wb_rob),
    .commit_valid(commit_valid), .commit_rob(commit_rob),
    .commit_ready(commit_ready), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  bit m_q[$];
  int m_head = 0, m_fid = 0;
  bit m_fl = 0;

  function automatic bit m_ready();
    return !m_fl && m_q.size() < 16 && !(bco_valid || snoop_hit);
  endfunction
  function automatic bit m_cv();
    return !m_fl && m_q.size() > 0 && m_q[0];
  endfunction

  task automatic m_reset();
    m_q.delete(); m_head = 0; m_fid = 0; m_fl = 0;
  endtask

  task automatic m_update();
    bit r, v;
    int off;
    r = m_ready(); v = m_cv();
    if (bco_valid || snoop_hit) begin
      m_q.delete(); m_fl = 1;
    end else begin
      m_fl = 0;
      off = (int'(wb_rob) - m_head + 16) % 16;
      if (wb_en && off < m_q.size()) m_q[off] = 1;
      if (v && commit_ready) begin void'(m_q.pop_front()); m_head = (m_head + 1) % 16; end
      if (r && alloc_req) begin m_q.push_back(0); m_fid = (m_fid + 1) % 256; end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic apply(input bit a, cr, we, input logic [3:0] wr, input bit b, s);
    alloc_req = a; commit_ready = cr; wb_en = we; wb_rob = wr; bco_valid = b; snoop_hit = s;
    #1;
    chk("m_ready", alloc_ready, m_ready());
    chk("m_rob", alloc_rob, (m_head + m_q.size()) % 16);
    chk("m_fid", alloc_fid, m_fid);
    chk("m_cv", commit_valid, m_cv());
    chk("m_crob", commit_rob, m_head);
    chk("m_count", count, m_q.size());
    chk("m_empty", empty, m_q.size() == 0);
    chk("m_full", full, m_q.size() == 16);
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0);
    resetn = 0;
    repeat (2) @(negedge clk);
    m_reset();
    resetn = 1;
  endtask

  typedef struct {
    bit a, cr, we; logic [3:0] wr; bit b, s;
    bit er; logic [3:0] erob; logic [7:0] efid; bit ecv; logic [3:0] ecrob; logic [4:0] ecnt;
  } vec_t;
  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1,0,0,0,0,0, 1,0,0,0,0,0};
    tbl[1]  = '{1,0,0,0,0,0, 1,1,1,0,0,1};
    tbl[2]  = '{1,0,0,0,0,0, 1,2,2,0,0,2};
    tbl[3]  = '{0,1,1,2,0,0, 1,3,3,0,0,3};
    tbl[4]  = '{0,1,1,0,0,0, 1,3,3,0,0,3};
    tbl[5]  = '{0,1,0,0,0,0, 1,3,3,1,0,3};
    tbl[6]  = '{0,1,1,1,0,0, 1,3,3,0,1,2};
    tbl[7]  = '{0,1,0,0,0,0, 1,3,3,1,1,2};
    tbl[8]  = '{0,1,1,7,0,0, 1,3,3,1,2,1};
    tbl[9]  = '{0,1,1,3,0,0, 1,3,3,0,3,0};
    tbl[10] = '{0,1,0,0,0,0, 1,3,3,0,3,0};
    tbl[11] = '{1,0,0,0,0,0, 1,3,3,0,3,0};
    tbl[12] = '{0,0,1,3,0,0, 1,4,4,0,3,1};
    tbl[13] = '{0,0,0,0,0,0, 1,4,4,1,3,1};
    tbl[14] = '{1,1,0,0,1,0, 0,4,4,1,3,1};
    tbl[15] = '{0,0,0,0,0,0, 0,3,4,0,3,0};
    tbl[16] = '{1,0,0,0,0,0, 1,3,4,0,3,0};
    tbl[17] = '{1,0,0,0,0,1, 0,4,5,0,3,1};
    tbl[18] = '{0,0,0,0,0,1, 0,3,5,0,3,0};
    tbl[19] = '{0,0,0,0,0,0, 0,3,5,0,3,0};
    tbl[20] = '{1,0,0,0,0,0, 1,3,5,0,3,0};

    @(negedge clk);
    do_reset();
    apply(0, 0, 0, 0, 0, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", alloc_ready, 1);

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].a, tbl[i].cr, tbl[i].we, tbl[i].wr, tbl[i].b, tbl[i].s);
      chk($sformatf("v%0d_ready", i), alloc_ready, tbl[i].er);
      chk($sformatf("v%0d_rob", i), alloc_rob, tbl[i].erob);
      chk($sformatf("v%0d_fid", i), alloc_fid, tbl[i].efid);
      chk($sformatf("v%0d_cv", i), commit_valid, tbl[i].ecv);
      chk($sformatf("v%0d_crob", i), commit_rob, tbl[i].ecrob);
      chk($sformatf("v%0d_cnt", i), count, tbl[i].ecnt);
      tick();
    end

    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(1, 0, 0, 0, 0, 0);
      chk("fill_rob", alloc_rob, i);
      chk("fill_fid", alloc_fid, i);
      tick();
    end
    apply(1, 0, 1, 0, 0, 0);
    chk("full_flag", full, 1);
    chk("full_cnt", count, 16);
    chk("full_ready", alloc_ready, 0);
    tick();
    apply(1, 1, 0, 0, 0, 0);
    chk("full_cv", commit_valid, 1);
    chk("full_noalloc", alloc_ready, 0);
    tick();
    apply(1, 0, 0, 0, 0, 0);
    chk("wrap_rob", alloc_rob, 0);
    chk("wrap_ready", alloc_ready, 1);
    tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("wrap_cnt", count, 16);
    tick();

    do_reset();
    for (int i = 0; i < 7; i++) begin apply(1, 0, 0, 0, 0, 0); tick(); end
    apply(0, 0, 0, 0, 0, 0);
    chk("pre_rst_cnt", count, 7);
    #2 resetn = 0;
    #1;
    chk("arst_cnt", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_rob", alloc_rob, 0);
    chk("arst_fid", alloc_fid, 0);
    m_reset();
    @(negedge clk);
    resetn = 1;

    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 1),
            4'((m_head + $urandom_range(0, m_q.size() + 1)) % 16),
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
